branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side branch predictor: the producer of the predicted-taken bit that
//  branch resolution later checks. Direct-mapped table of 2-bit saturating
//  counters plus branch target buffer (tag, target, valid), indexed by PC.
//  Looks up at fetch (1-cycle latency); trained by the resolved outcome from
//  the branch unit in execute.
// PARAMETERS
//  ENTRIES    64  table depth; power of 2, >= 2; INDEX_BITS = $clog2(ENTRIES)
//  TAG_BITS   10  PC tag width stored per entry; 1..(62-INDEX_BITS)
// PORTS
//  clk                 in   1   clock, all state on rising edge
//  reset_n             in   1   asynchronous, active-low reset
//  lookup_valid_in     in   1   fetch PC valid this cycle
//  lookup_pc_in        in   64  fetch PC
//  stall_in            in   1   hold prediction outputs; lookup ignored
//  predicted_valid_out out  1   prediction registers hold a valid result
//  predicted_taken_out out  1   predict taken
//  predicted_pc_out    out  64  next fetch PC
//  update_valid_in     in   1   resolved branch/jump this cycle
//  update_pc_in        in   64  PC of resolved branch
//  update_taken_in     in   1   actual outcome
//  update_target_in    in   64  resolved target (bits [1:0] stored as 0)
// BEHAVIOUR
//  Reset (async assert, sync-safe release): all valid bits 0, all counters
//   2'b01; predicted_valid_out=0, predicted_taken_out=0, predicted_pc_out=0.
//  Fields: index = pc[INDEX_BITS+1:2];
//   tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
//  Counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken=cnt[1].
//  Lookup (stall_in=0): next edge registers
//   valid_out = lookup_valid_in;
//   hit = valid[idx] && tag[idx]==tag(pc);
//   taken_out = hit && cnt[idx][1];
//   pc_out = taken_out ? target[idx] : pc+4 (64-bit wrap, carry dropped).
//   If lookup_valid_in=0: valid_out=0, taken_out=0, pc_out holds last value.
//  stall_in=1: all three prediction outputs hold; updates still proceed.
//  Update (update_valid_in=1), on next edge:
//   hit, taken:       cnt=sat_inc(cnt); target=update_target_in&~64'h3
//   hit, not taken:   cnt=sat_dec(cnt); target unchanged
//   miss, taken:      allocate/overwrite: valid=1, tag, target, cnt=2'b10
//   miss, not taken:  no change (no allocation)
//   Saturation: 11+inc=11, 00+dec=00; never wraps.
//  Same-cycle lookup+update to same index: lookup uses pre-update state (read
//   before write); next lookup sees updated state. No bypass.
//  No other state; single-cycle update, no backpressure on update port.
//  Reset mid-operation: table and outputs cleared immediately, no pending
//   update survives.
// TESTING
//  1 Reset, lookup pc=0x1000 -> next cycle valid=1, taken=0,
//    pc_out=0x1004.
//  2 Update pc=0x1000 taken tgt=0x2002, then lookup 0x1000 ->
//    taken=1, pc_out=0x2000.
//  3 Counter: after alloc (10), 2 taken updates (->11), 2 not-taken (->01):
//    lookup -> taken=0, pc_out=0x1004; 3rd not-taken stays 00, 1 taken ->01
//    still NT.
//  4 Alias: alloc 0x1000; lookup 0x1000+(ENTRIES*4) (same idx, diff tag)
//    -> taken=0, pc_out=addr+4.
//  5 Same-cycle update(0x1000 taken)+lookup(0x1000) on empty table ->
//    taken=0; following lookup -> taken=1.
//  6 stall_in=1 with new lookups -> outputs frozen; reset_n pulse mid-stream
//    -> outputs 0 at once, prior entries miss.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit saturating counters plus a
// BTB (tag/target/valid). One-cycle lookup, single-cycle training from execute.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lookup_valid_in,
  input  logic [63:0] lookup_pc_in,
  input  logic        stall_in,
  output logic        predicted_valid_out,
  output logic        predicted_taken_out,
  output logic [63:0] predicted_pc_out,
  input  logic        update_valid_in,
  input  logic [63:0] update_pc_in,
  input  logic        update_taken_in,
  input  logic [63:0] update_target_in
);

  localparam int INDEX_BITS = $clog2(ENTRIES);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [ENTRIES-1:0]                valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]           cnt_q, cnt_d;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][63:0]          target_q, target_d;

  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [63:0] pred_pc_q, pred_pc_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_taken, up_hit;

  assign lk_idx = lookup_pc_in[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc_in[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign up_idx = update_pc_in[INDEX_BITS+1:2];
  assign up_tag = update_pc_in[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Lookup reads the pre-update table; no bypass from the update port.
  assign lk_taken = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && cnt_q[lk_idx][1];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  logic unused_bits;
  assign unused_bits = ^{update_pc_in, update_target_in[1:0]};

  always_comb begin
    pred_valid_d = pred_valid_q;
    pred_taken_d = pred_taken_q;
    pred_pc_d    = pred_pc_q;
    if (!stall_in) begin
      pred_valid_d = lookup_valid_in;
      pred_taken_d = lookup_valid_in && lk_taken;
      if (lookup_valid_in) begin
        pred_pc_d = lk_taken ? target_q[lk_idx] : lookup_pc_in + 64'd4;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (update_valid_in) begin
      if (up_hit) begin
        if (update_taken_in) begin
          cnt_d[up_idx]    = sat_inc(cnt_q[up_idx]);
          target_d[up_idx] = update_target_in & ~64'h3;
        end else begin
          cnt_d[up_idx] = sat_dec(cnt_q[up_idx]);
        end
      end else if (update_taken_in) begin
        // Not-taken misses never allocate, so only taken branches claim entries.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target_in & ~64'h3;
        cnt_d[up_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      cnt_q        <= {ENTRIES{2'b01}};
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_pc_q    <= pred_pc_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign predicted_valid_out = pred_valid_q;
  assign predicted_taken_out = pred_taken_q;
  assign predicted_pc_out    = pred_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, counter saturation, aliasing,
// read-before-write, stall hold, async reset and PC wrap.
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic        lookup_valid_in;
  logic [63:0] lookup_pc_in;
  logic        stall_in;
  logic        predicted_valid_out;
  logic        predicted_taken_out;
  logic [63:0] predicted_pc_out;
  logic        update_valid_in;
  logic [63:0] update_pc_in;
  logic        update_taken_in;
  logic [63:0] update_target_in;

  int passed = 0;
  int total  = 0;

  branch_predictor #(.ENTRIES(64), .TAG_BITS(10)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .lookup_valid_in     (lookup_valid_in),
    .lookup_pc_in        (lookup_pc_in),
    .stall_in            (stall_in),
    .predicted_valid_out (predicted_valid_out),
    .predicted_taken_out (predicted_taken_out),
    .predicted_pc_out    (predicted_pc_out),
    .update_valid_in     (update_valid_in),
    .update_pc_in        (update_pc_in),
    .update_taken_in     (update_taken_in),
    .update_target_in    (update_target_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_pred(input string tag, input logic v, input logic t, input logic [63:0] pc);
    chk({tag, ".valid"}, {63'd0, predicted_valid_out}, {63'd0, v});
    chk({tag, ".taken"}, {63'd0, predicted_taken_out}, {63'd0, t});
    chk({tag, ".pc"}, predicted_pc_out, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid_in = 1'b0;
    update_valid_in = 1'b0;
  endtask

  task automatic lookup(input logic [63:0] pc);
    lookup_valid_in = 1'b1;
    lookup_pc_in    = pc;
  endtask

  task automatic update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    update_valid_in  = 1'b1;
    update_pc_in     = pc;
    update_taken_in  = tk;
    update_target_in = tgt;
  endtask

  task automatic upd_only(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
    idle();
    update(pc, tk, tgt);
    step();
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    stall_in = 1'b0;
    lookup_valid_in = 1'b0;
    lookup_pc_in = '0;
    update_valid_in = 1'b0;
    update_pc_in = '0;
    update_taken_in = 1'b0;
    update_target_in = '0;
    #12;
    chk_pred("reset", 1'b0, 1'b0, 64'h0);
    reset_n = 1'b1;

    // Cold lookup misses
    lookup(64'h1000); step();
    chk_pred("cold", 1'b1, 1'b0, 64'h1004);

    // Allocate on taken miss; idle lookup holds pc_out
    idle(); update(64'h1000, 1'b1, 64'h2002); step();
    chk_pred("idle_hold", 1'b0, 1'b0, 64'h1004);
    idle(); lookup(64'h1000); step();
    chk_pred("alloc", 1'b1, 1'b1, 64'h2000);

    // Counter: 10 ->11 ->11 (sat) ->11 with new target, then 10, 01
    upd_only(64'h1000, 1'b1, 64'h2002);
    upd_only(64'h1000, 1'b1, 64'h2002);
    upd_only(64'h1000, 1'b1, 64'h3008);
    upd_only(64'h1000, 1'b0, 64'h0);
    upd_only(64'h1000, 1'b0, 64'h0);
    lookup(64'h1000); step();
    chk_pred("cnt01", 1'b1, 1'b0, 64'h1004);

    // 01 ->00 ->00 (sat) ->01 still not taken
    upd_only(64'h1000, 1'b0, 64'h0);
    upd_only(64'h1000, 1'b0, 64'h0);
    upd_only(64'h1000, 1'b1, 64'h3008);
    lookup(64'h1000); step();
    chk_pred("cnt_sat0", 1'b1, 1'b0, 64'h1004);

    // 01 ->10 taken again
    upd_only(64'h1000, 1'b1, 64'h3008);
    lookup(64'h1000); step();
    chk_pred("cnt10", 1'b1, 1'b1, 64'h3008);

    // Not-taken miss at the same index must not allocate or disturb
    upd_only(64'h2000, 1'b0, 64'h7000);
    lookup(64'h1000); step();
    chk_pred("nt_miss", 1'b1, 1'b1, 64'h3008);
    lookup(64'h2000); step();
    chk_pred("nt_miss_noalloc", 1'b1, 1'b0, 64'h2004);

    // Alias: same index, different tag
    lookup(64'h1100); step();
    chk_pred("alias", 1'b1, 1'b0, 64'h1104);

    // Same-cycle update and lookup: read before write
    idle(); update(64'h1010, 1'b1, 64'h4000); lookup(64'h1010); step();
    chk_pred("rbw_old", 1'b1, 1'b0, 64'h1014);
    idle(); lookup(64'h1010); step();
    chk_pred("rbw_new", 1'b1, 1'b1, 64'h4000);

    // Stall freezes outputs while the update port keeps training
    stall_in = 1'b1;
    idle(); lookup(64'h1000); update(64'h1020, 1'b1, 64'h5000); step();
    chk_pred("stall1", 1'b1, 1'b1, 64'h4000);
    idle(); lookup(64'h1100); step();
    chk_pred("stall2", 1'b1, 1'b1, 64'h4000);
    stall_in = 1'b0;
    idle(); lookup(64'h1020); step();
    chk_pred("stall_upd", 1'b1, 1'b1, 64'h5000);

    // Asynchronous reset pulse mid-cycle
    idle();
    reset_n = 1'b0;
    #2;
    chk_pred("async_rst", 1'b0, 1'b0, 64'h0);
    reset_n = 1'b1;
    lookup(64'h1020); step();
    chk_pred("post_rst_a", 1'b1, 1'b0, 64'h1024);
    lookup(64'h1000); step();
    chk_pred("post_rst_b", 1'b1, 1'b0, 64'h1004);

    // Fall-through PC wraps at 64 bits
    lookup(64'hFFFF_FFFF_FFFF_FFFC); step();
    chk_pred("wrap", 1'b1, 1'b0, 64'h0);

    idle(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
